// File: rtl/fetch_addr_fifo_pkg.sv
// -----------------------------------------------------------------------------
// fetch_addr_fifo_pkg
// Shared constants and elaboration-time helpers for the fetch address FIFO.
//   clog2        : constant ceil(log2()) used to size pointers and COUNT
//   depth_legal  : DEPTH must lie in MIN_DEPTH..MAX_DEPTH
//   thresh_legal : AFULL_THRESH must lie in 1..DEPTH
// -----------------------------------------------------------------------------
package fetch_addr_fifo_pkg;

   localparam int MIN_DEPTH = 2;
   localparam int MAX_DEPTH = 64;

   // Smallest r with 2**r >= value; 0 for value <= 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   function automatic bit depth_legal(input int depth);
      return (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH);
   endfunction

   function automatic bit thresh_legal(input int thresh, input int depth);
      return (thresh >= 1) && (thresh <= depth);
   endfunction

endpackage

// File: rtl/fetch_addr_fifo_mem.sv
// -----------------------------------------------------------------------------
// fetch_addr_fifo_mem
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous
// read port. Deliberately unreset so it can map onto LUTRAM or plain flops.
// Ports:
//   CLK    in   clock
//   we     in   write enable
//   waddr  in   write address (clog2(DEPTH) bits)
//   wdata  in   write data (WIDTH bits)
//   raddr  in   read address (clog2(DEPTH) bits)
//   rdata  out  read data, combinational from raddr
// -----------------------------------------------------------------------------
module fetch_addr_fifo_mem
   import fetch_addr_fifo_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int AW    = clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_r [DEPTH];

   // Storage write port.
   always_ff @(posedge CLK) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/fetch_addr_fifo.sv
// -----------------------------------------------------------------------------
// fetch_addr_fifo
// First-word-fall-through FIFO carrying fetch PCs from the PC generator (top
// side) to the L1-I miss / L2 request logic (bottom side). Valid/ready on both
// sides, registered occupancy COUNT, almost-full flag, single-cycle FLUSH.
//
// Optional feature macro: FETCH_FIFO_BYPASS_EN
//   defined   : an empty FIFO forwards DATA_IN to DATA_OUT in the same cycle;
//               if the bottom consumes it, the entry is never stored.
//   undefined : no combinational path from the top side to the bottom side.
//
// Ports:
//   CLK          in   clock, rising edge
//   RST          in   synchronous active-high reset, highest priority
//   FLUSH        in   drop every stored entry (a same-cycle push survives)
//   TOP_VALID    in   upstream offers DATA_IN
//   TOP_READY    out  FIFO can accept (= !FULL, registered)
//   DATA_IN      in   PC to push
//   BOT_VALID    out  DATA_OUT holds a valid head entry
//   BOT_READY    in   downstream consumes the head this cycle
//   DATA_OUT     out  head entry, 0 when BOT_VALID=0
//   EMPTY        out  COUNT==0
//   FULL         out  COUNT==DEPTH
//   ALMOST_FULL  out  COUNT>=AFULL_THRESH
//   COUNT        out  stored-entry count
// -----------------------------------------------------------------------------
module fetch_addr_fifo
   import fetch_addr_fifo_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int DEPTH        = 4,
   parameter int AFULL_THRESH = DEPTH - 1
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      FLUSH,
   input  logic                      TOP_VALID,
   output logic                      TOP_READY,
   input  logic [WIDTH-1:0]          DATA_IN,
   output logic                      BOT_VALID,
   input  logic                      BOT_READY,
   output logic [WIDTH-1:0]          DATA_OUT,
   output logic                      EMPTY,
   output logic                      FULL,
   output logic                      ALMOST_FULL,
   output logic [clog2(DEPTH+1)-1:0] COUNT
);

   localparam int AW = clog2(DEPTH);
   localparam int CW = clog2(DEPTH + 1);

   if (!depth_legal(DEPTH)) begin : g_depth_illegal
      $error("fetch_addr_fifo: DEPTH=%0d outside legal range 2..64", DEPTH);
   end
   if (!thresh_legal(AFULL_THRESH, DEPTH)) begin : g_thresh_illegal
      $error("fetch_addr_fifo: AFULL_THRESH=%0d outside legal range 1..DEPTH", AFULL_THRESH);
   end

   logic [AW-1:0]    rd_ptr_r, wr_ptr_r;
   logic [AW-1:0]    rd_ptr_nxt_s, wr_ptr_nxt_s, waddr_s;
   logic [CW-1:0]    count_r, count_nxt_s;
   logic             empty_r, full_r, afull_r;
   logic             push_s, byp_active_s, byp_consume_s;
   logic             bot_valid_s, wr_en_s, rd_adv_s;
   logic [WIDTH-1:0] rdata_s;

   // Pointers wrap at DEPTH-1 explicitly so non-power-of-two depths work.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      if (p == AW'(DEPTH - 1)) begin
         return {AW{1'b0}};
      end else begin
         return p + AW'(1);
      end
   endfunction

   // Handshake decode: push/pop qualification, bypass detection, write address.
   always_comb begin
      push_s = TOP_VALID & ~full_r;
`ifdef FETCH_FIFO_BYPASS_EN
      byp_active_s = empty_r & TOP_VALID & ~FLUSH;
`else
      byp_active_s = 1'b0;
`endif
      bot_valid_s   = (~empty_r & ~FLUSH) | byp_active_s;
      // A bypassed entry that is consumed immediately never touches storage.
      byp_consume_s = byp_active_s & BOT_READY;
      wr_en_s       = push_s & ~byp_consume_s & ~RST;
      rd_adv_s      = ~empty_r & ~FLUSH & BOT_READY;
      // FLUSH rewinds the write pointer, so a same-cycle push lands in slot 0.
      if (FLUSH) begin
         waddr_s = {AW{1'b0}};
      end else begin
         waddr_s = wr_ptr_r;
      end
   end

   // Next-state for pointers and occupancy.
   always_comb begin
      rd_ptr_nxt_s = rd_ptr_r;
      wr_ptr_nxt_s = wr_ptr_r;
      count_nxt_s  = count_r;
      if (FLUSH) begin
         rd_ptr_nxt_s = {AW{1'b0}};
         if (wr_en_s) begin
            wr_ptr_nxt_s = AW'(1);
            count_nxt_s  = CW'(1);
         end else begin
            wr_ptr_nxt_s = {AW{1'b0}};
            count_nxt_s  = {CW{1'b0}};
         end
      end else begin
         if (wr_en_s) begin
            wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
         end else begin
            wr_ptr_nxt_s = wr_ptr_r;
         end
         if (rd_adv_s) begin
            rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
         end else begin
            rd_ptr_nxt_s = rd_ptr_r;
         end
         case ({wr_en_s, rd_adv_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
         endcase
      end
   end

   // State registers; flags are registered from the next count.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_ptr_r <= {AW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         empty_r  <= 1'b1;
         full_r   <= 1'b0;
         afull_r  <= 1'b0;
      end else begin
         rd_ptr_r <= rd_ptr_nxt_s;
         wr_ptr_r <= wr_ptr_nxt_s;
         count_r  <= count_nxt_s;
         empty_r  <= (count_nxt_s == {CW{1'b0}});
         full_r   <= (count_nxt_s == CW'(DEPTH));
         afull_r  <= (count_nxt_s >= CW'(AFULL_THRESH));
      end
   end

   fetch_addr_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .CLK   (CLK),
      .we    (wr_en_s),
      .waddr (waddr_s),
      .wdata (DATA_IN),
      .raddr (rd_ptr_r),
      .rdata (rdata_s)
   );

   // Bottom-side data mux: bypass, stored head, or zero when nothing valid.
   always_comb begin
      if (!bot_valid_s) begin
         DATA_OUT = {WIDTH{1'b0}};
      end else if (byp_active_s) begin
         DATA_OUT = DATA_IN;
      end else begin
         DATA_OUT = rdata_s;
      end
   end

   assign TOP_READY   = ~full_r;
   assign BOT_VALID   = bot_valid_s;
   assign EMPTY       = empty_r;
   assign FULL        = full_r;
   assign ALMOST_FULL = afull_r;
   assign COUNT       = count_r;

endmodule

// File: tb/tb_fetch_addr_fifo.sv
// -----------------------------------------------------------------------------
// tb_fetch_addr_fifo
// Drives a DEPTH=4 and a DEPTH=3 instance with identical stimulus. A queue per
// instance models the FIFO contents; expected outputs are derived from queue
// size and head. Directed scenarios also check hand-computed constants.
// -----------------------------------------------------------------------------
module tb_fetch_addr_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flush, top_valid, bot_ready;
   logic [31:0] data_in;

   logic        tr4, bv4, em4, fu4, af4;
   logic [2:0]  cnt4;
   logic [31:0] do4;
   logic        tr3, bv3, em3, fu3, af3;
   logic [1:0]  cnt3;
   logic [31:0] do3;

   int checks   = 0;
   int failures = 0;

   fetch_addr_fifo #(.WIDTH(32), .DEPTH(4), .AFULL_THRESH(3)) u_dut4 (
      .CLK(clk), .RST(rst), .FLUSH(flush),
      .TOP_VALID(top_valid), .TOP_READY(tr4), .DATA_IN(data_in),
      .BOT_VALID(bv4), .BOT_READY(bot_ready), .DATA_OUT(do4),
      .EMPTY(em4), .FULL(fu4), .ALMOST_FULL(af4), .COUNT(cnt4)
   );

   fetch_addr_fifo #(.WIDTH(32), .DEPTH(3), .AFULL_THRESH(2)) u_dut3 (
      .CLK(clk), .RST(rst), .FLUSH(flush),
      .TOP_VALID(top_valid), .TOP_READY(tr3), .DATA_IN(data_in),
      .BOT_VALID(bv3), .BOT_READY(bot_ready), .DATA_OUT(do3),
      .EMPTY(em3), .FULL(fu3), .ALMOST_FULL(af3), .COUNT(cnt3)
   );

`ifdef FETCH_FIFO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   // Reference model: index 0 -> DEPTH 4, index 1 -> DEPTH 3.
   logic [31:0] mq [2][$];

   function automatic int mdepth(input int idx);
      return (idx == 0) ? 4 : 3;
   endfunction

   // Expected {top_ready, bot_valid, empty, full, afull, count[2:0], data_out}.
   function automatic logic [39:0] mexp(input int idx);
      int          n, d;
      logic        bv;
      logic [31:0] dout;
      n    = mq[idx].size();
      d    = mdepth(idx);
      bv   = (n > 0) && !flush;
      dout = bv ? mq[idx][0] : 32'd0;
      if (BYP && n == 0 && top_valid && !flush) begin
         bv   = 1'b1;
         dout = data_in;
      end
      return {(n < d), bv, (n == 0), (n == d), (n >= d - 1), 3'(n), dout};
   endfunction

   function automatic logic [79:0] mexp_all();
      return {mexp(0), mexp(1)};
   endfunction

   function automatic logic [79:0] obs_all();
      return {tr4, bv4, em4, fu4, af4, cnt4, do4,
              tr3, bv3, em3, fu3, af3, 1'b0, cnt3, do3};
   endfunction

   // Apply the inputs held across the last rising edge to the model.
   task automatic mupd();
      for (int idx = 0; idx < 2; idx++) begin
         int n, d;
         bit push, bv, byp;
         n    = mq[idx].size();
         d    = mdepth(idx);
         push = top_valid && (n < d);
         bv   = (n > 0) && !flush;
         byp  = BYP && (n == 0) && top_valid && !flush;
         if (rst) begin
            mq[idx].delete();
         end else if (flush) begin
            mq[idx].delete();
            if (push) mq[idx].push_back(data_in);
         end else if (byp && bot_ready) begin
            // consumed straight through, nothing stored
         end else begin
            if (bv && bot_ready) void'(mq[idx].pop_front());
            if (push) mq[idx].push_back(data_in);
         end
      end
   endtask

   task automatic drive(input logic r, input logic f, input logic tv,
                        input logic [31:0] d, input logic br);
      @(negedge clk);
      rst = r; flush = f; top_valid = tv; data_in = d; bot_ready = br;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      mupd();
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      checks++;
      if ({tr4, bv4, em4, fu4, af4, cnt4, do4} !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0}) begin
         failures++;
         $display("FAIL reset_state4 got=%h exp=%h", {tr4, bv4, em4, fu4, af4, cnt4, do4},
                  {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0});
      end
      checks++;
      if (obs_all() !== mexp_all()) begin
         failures++;
         $display("FAIL reset_model got=%h exp=%h", obs_all(), mexp_all());
      end
      tick();
   endtask

   task automatic test_fill();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b1, 32'h100 + 32'(4 * i), 1'b0);
         checks++;
         if ({cnt4, af4, tr4} !== {3'(i > 4 ? 4 : (i == 4 ? 4 : i)), (i >= 3), (i < 4)}) begin
            failures++;
            $display("FAIL fill_step%0d got cnt=%0d af=%b tr=%b exp cnt=%0d af=%b tr=%b",
                     i, cnt4, af4, tr4, (i == 4 ? 4 : i), (i >= 3), (i < 4));
         end
         checks++;
         if (obs_all() !== mexp_all()) begin
            failures++;
            $display("FAIL fill_model%0d got=%h exp=%h", i, obs_all(), mexp_all());
         end
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      checks++;
      if ({cnt4, fu4, tr4, af4, do4} !== {3'd4, 1'b1, 1'b0, 1'b1, 32'h100}) begin
         failures++;
         $display("FAIL fill_full got cnt=%0d full=%b tr=%b af=%b dout=%h exp 4 1 0 1 00000100",
                  cnt4, fu4, tr4, af4, do4);
      end
      tick();
   endtask

   task automatic test_drain();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
         checks++;
         if ({bv4, do4} !== {1'b1, 32'h100 + 32'(4 * i)}) begin
            failures++;
            $display("FAIL drain_order%0d got bv=%b dout=%h exp bv=1 dout=%h",
                     i, bv4, do4, 32'h100 + 32'(4 * i));
         end
         checks++;
         if (obs_all() !== mexp_all()) begin
            failures++;
            $display("FAIL drain_model%0d got=%h exp=%h", i, obs_all(), mexp_all());
         end
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      checks++;
      if ({em4, bv4, do4, cnt4} !== {1'b1, 1'b0, 32'd0, 3'd0}) begin
         failures++;
         $display("FAIL drain_empty got em=%b bv=%b dout=%h cnt=%0d exp 1 0 0 0",
                  em4, bv4, do4, cnt4);
      end
      tick();
   endtask

   task automatic test_stream();
      for (int k = 0; k <= 10; k++) begin
         drive(1'b0, 1'b0, (k < 10), 32'(k), 1'b1);
         if (k >= 1 && k <= 9) begin
            checks++;
            if ({bv4, do4, cnt4, cnt3, do3} !==
                {1'b1, 32'(BYP ? k : k - 1), 3'(BYP ? 0 : 1), 2'(BYP ? 0 : 1), 32'(BYP ? k : k - 1)}) begin
               failures++;
               $display("FAIL stream%0d got bv=%b d4=%h c4=%0d c3=%0d d3=%h exp d=%0d c=%0d",
                        k, bv4, do4, cnt4, cnt3, do3, (BYP ? k : k - 1), (BYP ? 0 : 1));
            end
         end
         checks++;
         if (obs_all() !== mexp_all()) begin
            failures++;
            $display("FAIL stream_model%0d got=%h exp=%h", k, obs_all(), mexp_all());
         end
         tick();
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b1, 32'hA0 + 32'(4 * i), 1'b0);
         tick();
      end
      drive(1'b0, 1'b1, 1'b1, 32'h200, 1'b1);
      checks++;
      if ({cnt4, bv4, do4} !== {3'd3, 1'b0, 32'd0}) begin
         failures++;
         $display("FAIL flush_cycle got cnt=%0d bv=%b dout=%h exp 3 0 0", cnt4, bv4, do4);
      end
      checks++;
      if (obs_all() !== mexp_all()) begin
         failures++;
         $display("FAIL flush_model got=%h exp=%h", obs_all(), mexp_all());
      end
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      checks++;
      if ({cnt4, bv4, do4, cnt3} !== {3'd1, 1'b1, 32'h200, 2'd0}) begin
         failures++;
         $display("FAIL flush_after got c4=%0d bv=%b dout=%h c3=%0d exp 1 1 00000200 0",
                  cnt4, bv4, do4, cnt3);
      end
      checks++;
      if (obs_all() !== mexp_all()) begin
         failures++;
         $display("FAIL flush_after_model got=%h exp=%h", obs_all(), mexp_all());
      end
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      tick();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 1'b1, 32'h400 + 32'(4 * i), 1'b0);
         tick();
      end
      drive(1'b1, 1'b0, 1'b1, 32'h408, 1'b0);
      checks++;
      if (cnt4 !== 3'd2) begin
         failures++;
         $display("FAIL rstmid_pre got cnt=%0d exp 2", cnt4);
      end
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      checks++;
      if ({tr4, bv4, em4, fu4, af4, cnt4, do4, cnt3} !==
          {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 2'd0}) begin
         failures++;
         $display("FAIL rstmid_after got tr=%b bv=%b em=%b fu=%b af=%b c4=%0d d=%h c3=%0d exp 1 0 1 0 0 0 0 0",
                  tr4, bv4, em4, fu4, af4, cnt4, do4, cnt3);
      end
      checks++;
      if (obs_all() !== mexp_all()) begin
         failures++;
         $display("FAIL rstmid_model got=%h exp=%h", obs_all(), mexp_all());
      end
      tick();
   endtask

   task automatic test_bypass();
      drive(1'b0, 1'b0, 1'b1, 32'h300, 1'b1);
      checks++;
      if ({bv4, do4} !== {BYP, (BYP ? 32'h300 : 32'd0)}) begin
         failures++;
         $display("FAIL bypass_same got bv=%b dout=%h exp bv=%b", bv4, do4, BYP);
      end
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      checks++;
      if ({cnt4, bv4, do4} !== {3'(BYP ? 0 : 1), !BYP, (BYP ? 32'd0 : 32'h300)}) begin
         failures++;
         $display("FAIL bypass_next got cnt=%0d bv=%b dout=%h", cnt4, bv4, do4);
      end
      checks++;
      if (obs_all() !== mexp_all()) begin
         failures++;
         $display("FAIL bypass_model got=%h exp=%h", obs_all(), mexp_all());
      end
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         logic r, f, tv, br;
         r  = ($urandom_range(0, 99) == 0);
         f  = ($urandom_range(0, 19) == 0);
         tv = (c % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         br = (c % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         drive(r, f, tv, $urandom, br);
         checks++;
         if (obs_all() !== mexp_all()) begin
            failures++;
            $display("FAIL random_model%0d got=%h exp=%h", c, obs_all(), mexp_all());
         end
         tick();
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; top_valid = 1'b0; bot_ready = 1'b0; data_in = 32'd0;
      test_reset();
      test_fill();
      test_drain();
      test_stream();
      test_flush();
      test_reset_mid();
      test_bypass();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_addr_fifo.md
# fetch_addr_fifo

Parametrised first-word-fall-through FIFO carrying fetch addresses (PCs) from the instruction-fetch unit to the L2 request path. It generalises the fixed three-entry fetch queue to an arbitrary depth. It adds a full valid/ready handshake on both sides, an occupancy count, an almost-full flag and a single-cycle flush for branch mispredicts. Sits between the PC generator (top) and the L1-I miss / L2 request logic (bottom).

## Interface
Parameters:
- WIDTH, 32, bits per entry (PC width).
- DEPTH, 4, number of entries; legal range 2..64, not required to be a power of two.
- AFULL_THRESH, DEPTH-1, ALMOST_FULL asserts when COUNT >= AFULL_THRESH; legal range 1..DEPTH.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, synchronous, active-high.
- FLUSH  in  1  discard all stored entries.
- TOP_VALID  in  1  upstream has an entry on DATA_IN.
- TOP_READY  out  1  FIFO can accept; equals !FULL.
- DATA_IN  in  WIDTH  entry to push.
- BOT_VALID  out  1  DATA_OUT holds a valid head entry.
- BOT_READY  in  1  downstream consumes the head this cycle.
- DATA_OUT  out  WIDTH  head entry; forced to 0 when BOT_VALID=0.
- EMPTY  out  1  COUNT==0.
- FULL  out  1  COUNT==DEPTH.
- ALMOST_FULL  out  1  COUNT >= AFULL_THRESH.
- COUNT  out  clog2(DEPTH+1)  stored-entry count, registered.

## Operation
- Storage is a circular buffer with read pointer rd_ptr and write pointer wr_ptr, each clog2(DEPTH) bits.
  - Each pointer wraps from DEPTH-1 to 0 by explicit compare, not by modulo 2^n.
- Push is accepted when TOP_VALID & TOP_READY: write mem[wr_ptr] <= DATA_IN, then advance wr_ptr.
- Pop is accepted when BOT_VALID & BOT_READY: advance rd_ptr.
- COUNT update: +1 on push only, -1 on pop only, unchanged on both or neither.
  - COUNT never exceeds DEPTH and never underflows. Both follow from the handshake; the verifier asserts them.
- TOP_READY is derived from registered FULL only. There is no combinational path from BOT_READY to TOP_READY.
  - When full, a push is refused even if a pop occurs in the same cycle.
- BOT_VALID = !EMPTY & !FLUSH, with the bypass term added when configured.
- DATA_OUT = mem[rd_ptr], read combinationally.
- FLUSH, evaluated after RST:
  - Pointers reset to 0 and COUNT goes to 0.
  - A push accepted in the same cycle is written to mem[0]. The next cycle then has COUNT=1, wr_ptr=1 and BOT_VALID=1.
  - BOT_VALID is 0 during the FLUSH cycle, so no pop occurs.
- RST has priority over everything:
  - Next cycle: COUNT=0, pointers 0, EMPTY=1, FULL=0, TOP_READY=1, BOT_VALID=0, DATA_OUT=0.
  - ALMOST_FULL=0 (AFULL_THRESH >= 1).
  - Storage contents are not reset.
- Reset mid-operation drops all entries. A push in the reset cycle is lost.

## Timing
- Latency without bypass: an entry pushed in cycle N is visible on DATA_OUT with BOT_VALID=1 in cycle N+1.
- Throughput: one push and one pop per cycle, sustained, for any COUNT in 1..DEPTH-1.
- EMPTY, FULL, ALMOST_FULL and COUNT are all registered or decoded from registered COUNT. They update in the cycle after the causing handshake.
- Wrap-around: a push at wr_ptr=DEPTH-1 writes the last slot, and wr_ptr becomes 0 next cycle. rd_ptr wraps the same way.
- Head stability: DATA_OUT holds its value while BOT_VALID=1 and BOT_READY=0, regardless of pushes.

## Configuration
- FETCH_FIFO_BYPASS_EN defined:
  - When EMPTY & TOP_VALID & !FLUSH, then BOT_VALID=1 and DATA_OUT=DATA_IN in the same cycle (zero latency).
  - If BOT_READY is also 1, the entry is consumed directly: not written, pointers and COUNT unchanged.
  - If BOT_READY is 0, the entry is written normally and COUNT becomes 1.
- Undefined: no combinational path from DATA_IN or TOP_VALID to the bottom side; 1-cycle latency as above.

## Structure
- Shared package/header holds:
  - the clog2 constant function;
  - parameter-legality checks, DEPTH range and AFULL_THRESH <= DEPTH, as elaboration-time errors.
- Sub-module fetch_addr_fifo_mem:
  - DEPTH x WIDTH register file, one synchronous write port, one asynchronous read port;
  - no reset, so it maps to LUTRAM or flops.
- Top module holds the pointers, COUNT, flags, flush/reset logic and the bypass mux.

## Test plan
- Reset, then fill: DEPTH=4, push 0x100, 0x104, 0x108, 0x10C with BOT_READY=0.
  - COUNT steps 1..4.
  - ALMOST_FULL rises when COUNT=3.
  - FULL=1 and TOP_READY=0 after the 4th push.
  - A 5th push of 0x110 is refused.
- Drain: from full, BOT_READY=1 for 4 cycles.
  - DATA_OUT reads 0x100, 0x104, 0x108, 0x10C in order.
  - Then EMPTY=1, BOT_VALID=0, DATA_OUT=0.
- Wrap and stream: DEPTH=3, continuous push and pop of 0x0..0x9 for 10 cycles.
  - Output order matches input.
  - COUNT stays 1 and pointers wrap through 0.
- Flush with push: COUNT=3, assert FLUSH with a push of 0x200.
  - Next cycle COUNT=1, DATA_OUT=0x200, BOT_VALID=1.
  - No pop is recorded during the FLUSH cycle.
- Reset mid-stream: COUNT=2, assert RST together with a push.
  - Next cycle all outputs at reset values and COUNT=0.
- Bypass, macro defined: empty FIFO, TOP_VALID=1, DATA_IN=0x300, BOT_READY=1.
  - Same cycle BOT_VALID=1 and DATA_OUT=0x300.
  - Next cycle COUNT=0.
  - With the macro undefined, BOT_VALID rises one cycle later instead.
